// File: rtl/memdata_pkg.sv
// Shared definitions for the data-memory block-copy engine: memory geometry and FSM states.
package memdata_pkg;

    localparam int MEM_AW = 9;
    localparam int MEM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/memdata_dma_port_mux.sv
// Data-memory port arbiter: the DMA owns we/address/data_in while it is busy, the pipeline otherwise.
module memdata_dma_port_mux
    import memdata_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) (
    input  logic          dma_sel_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    input  logic          pipe_we_i,
    input  logic [AW-1:0] pipe_addr_i,
    input  logic [DW-1:0] pipe_wdata_i,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_in_o
);

    // Port select between DMA master and pipeline MEM stage
    always_comb begin
        mem_we_o      = 1'b0;
        mem_addr_o    = {AW{1'b0}};
        mem_data_in_o = {DW{1'b0}};
        if (dma_sel_i) begin
            mem_we_o      = dma_we_i;
            mem_addr_o    = dma_addr_i;
            mem_data_in_o = dma_wdata_i;
        end else begin
            mem_we_o      = pipe_we_i;
            mem_addr_o    = pipe_addr_i;
            mem_data_in_o = pipe_wdata_i;
        end
    end

endmodule

// File: rtl/memdata_dma.sv
// Block-copy DMA master for the data memory (forward copy, READ/WRITE alternating per word).
// Optional MEMDATA_DMA_FILL_EN adds a fill mode that writes a constant word with no reads.
module memdata_dma
    import memdata_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW,
    parameter int LW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] length,
`ifdef MEMDATA_DMA_FILL_EN
    input  logic          fill_mode,
    input  logic [DW-1:0] fill_value,
`endif
    output logic          busy,
    output logic          done,
    output logic          mem_we,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] count_q, count_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          fill_q, fill_d;
    logic [DW-1:0] fillv_q, fillv_d;
    logic          fill_mode_s;
    logic [DW-1:0] fill_value_s;

`ifdef MEMDATA_DMA_FILL_EN
    assign fill_mode_s  = fill_mode;
    assign fill_value_s = fill_value;
`else
    assign fill_mode_s  = 1'b0;
    assign fill_value_s = {DW{1'b0}};
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            src_q   <= {AW{1'b0}};
            dst_q   <= {AW{1'b0}};
            count_q <= {LW{1'b0}};
            hold_q  <= {DW{1'b0}};
            fill_q  <= 1'b0;
            fillv_q <= {DW{1'b0}};
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            fill_q  <= fill_d;
            fillv_q <= fillv_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        hold_d  = hold_q;
        fill_d  = fill_q;
        fillv_d = fillv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    count_d = length;
                    fill_d  = fill_mode_s;
                    fillv_d = fill_value_s;
                    if (length == {LW{1'b0}}) begin
                        state_d = ST_DONE;
                    end else if (fill_mode_s) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                hold_d  = mem_rdata;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Addresses wrap modulo 2^AW by construction
                src_d   = src_q + AW'(1);
                dst_d   = dst_q + AW'(1);
                count_d = count_q - LW'(1);
                if (count_q == LW'(1)) begin
                    state_d = ST_DONE;
                end else if (fill_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only; no path from start
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_we      = 1'b0;
        mem_address = {AW{1'b0}};
        mem_wdata   = {DW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_READ: begin
                busy        = 1'b1;
                mem_address = src_q;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                mem_we      = 1'b1;
                mem_address = dst_q;
                mem_wdata   = fill_q ? fillv_q : hold_q;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
